// File: rtl/hpi_target_emu.sv
// hpi_target_emu: target (responder) end of the 16-bit HPI bus. Emulates the
// EZ-OTG HPI port: DATA (word RAM behind an auto-incrementing byte pointer),
// MAILBOX, ADDRESS and STATUS registers, OTG_INT toward the host and a
// local-side mailbox pair.
// Optional feature: define HPI_RANGE_ERR_EN to flag DATA accesses whose pointer
// lies beyond the RAM (STATUS bit 15, reads return 16'hDEAD, writes dropped).
// Without it the RAM index simply aliases modulo DEPTH_WORDS.
module hpi_target_emu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        mbx_out_full
);

  typedef enum logic [1:0] {
    A_DATA = 2'b00,
    A_MBX  = 2'b01,
    A_ADDR = 2'b10,
    A_STAT = 2'b11
  } hpi_reg_e;

  hpi_reg_e        w_addr;
  logic            w_rd;
  logic            w_wr;
  logic            w_soft;
  logic            w_wr_evt;
  logic            w_rd_end;
  logic            w_drive;
  logic            w_data_ok;
  logic            w_rng;
  logic [15:0]     w_ptr_next;
  logic [15:0]     w_rd_data;
  logic [AW-1:0]   w_ram_idx;

  logic            r_rd_q;
  logic            r_wr_q;
  hpi_reg_e        r_rd_addr;
  logic [15:0]     r_ptr;
  logic [15:0]     r_mbx_in_data;
  logic            r_mbx_in_valid;
  logic [15:0]     r_mbx_out;
  logic            r_mbx_out_full;
  logic            r_ovr;
  logic            r_int;
  logic [15:0]     r_ram [DEPTH_WORDS];

  assign w_addr     = hpi_reg_e'(OTG_ADDR);
  // A read only counts while no write strobe is present: the write wins.
  assign w_rd       = ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
  assign w_wr       = ~OTG_CS_N & ~OTG_WR_N;
  assign w_soft     = ~OTG_RST_N;
  assign w_wr_evt   = w_wr & ~r_wr_q & ~w_soft & ~Reset;
  assign w_rd_end   = r_rd_q & ~w_rd & ~w_soft & ~Reset;
  assign w_ptr_next = r_ptr + 16'd2;
  assign w_ram_idx  = r_ptr[AW:1];

`ifdef HPI_RANGE_ERR_EN
  logic w_ptr_oor;
  logic r_rng;
  assign w_ptr_oor = |r_ptr[15:AW+1];
  assign w_data_ok = ~w_ptr_oor;
  assign w_rng     = r_rng;

  // Sticky range-error flag: set on an out-of-range DATA access, cleared by a STATUS read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || w_soft) begin
      r_rng <= 1'b0;
    end else if (w_ptr_oor && ((w_wr_evt && w_addr == A_DATA) ||
                               (w_rd_end && r_rd_addr == A_DATA))) begin
      r_rng <= 1'b1;
    end else if (w_rd_end && r_rd_addr == A_STAT) begin
      r_rng <= 1'b0;
    end
  end
`else
  assign w_data_ok = 1'b1;
  assign w_rng     = 1'b0;
`endif

  // Strobe history for edge detection, plus the register a read is addressing.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd_q    <= 1'b0;
      r_wr_q    <= 1'b0;
      r_rd_addr <= A_DATA;
    end else begin
      r_rd_q <= w_rd;
      r_wr_q <= w_wr;
      if (w_rd) r_rd_addr <= w_addr;
    end
  end

  // Pointer, mailboxes and interrupt; host soft reset clears the same state as Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || w_soft) begin
      r_ptr          <= '0;
      r_mbx_in_data  <= '0;
      r_mbx_in_valid <= 1'b0;
      r_mbx_out      <= '0;
      r_mbx_out_full <= 1'b0;
      r_int          <= 1'b0;
    end else begin
      if (w_wr_evt && w_addr == A_ADDR)
        r_ptr <= {OTG_DATA[15:1], 1'b0};
      else if (w_wr_evt && w_addr == A_DATA)
        r_ptr <= w_ptr_next;
      else if (w_rd_end && r_rd_addr == A_DATA)
        r_ptr <= w_ptr_next;

      // A host write coinciding with the local ack keeps the new word valid.
      if (w_wr_evt && w_addr == A_MBX) begin
        r_mbx_in_data  <= OTG_DATA;
        r_mbx_in_valid <= 1'b1;
      end else if (mbx_in_ack) begin
        r_mbx_in_valid <= 1'b0;
      end

      // New local data beats a simultaneous host read-end.
      if (mbx_out_wr) begin
        r_mbx_out      <= mbx_out_data;
        r_mbx_out_full <= 1'b1;
      end else if (w_rd_end && r_rd_addr == A_MBX) begin
        r_mbx_out_full <= 1'b0;
      end

      r_int <= r_mbx_out_full;
    end
  end

  // Sticky overrun flag: set on a MAILBOX write over an unconsumed word, cleared by a STATUS read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset || w_soft) begin
      r_ovr <= 1'b0;
    end else if (w_wr_evt && w_addr == A_MBX && r_mbx_in_valid && !mbx_in_ack) begin
      r_ovr <= 1'b1;
    end else if (w_rd_end && r_rd_addr == A_STAT) begin
      r_ovr <= 1'b0;
    end
  end

  // Word RAM written by host DATA writes.
  // NOTE: the RAM has no reset so it maps onto memory macros and survives both resets.
  always_ff @(posedge Clk) begin
    if (w_wr_evt && w_addr == A_DATA && w_data_ok)
      r_ram[w_ram_idx] <= OTG_DATA;
  end

  // Read data mux, selected directly by the ADDR pins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    unique case (w_addr)
      A_DATA: w_rd_data = w_data_ok ? r_ram[w_ram_idx] : 16'hDEAD;
      A_MBX:  w_rd_data = r_mbx_out;
      A_ADDR: w_rd_data = r_ptr;
      A_STAT: w_rd_data = {w_rng, 12'b0, r_ovr, r_mbx_in_valid, r_mbx_out_full};
      default: w_rd_data = '0;
    endcase
  end

  // Bus released at once by Reset, whatever the strobes are doing.
  assign w_drive  = w_rd & ~Reset;
  assign OTG_DATA = w_drive ? w_rd_data : 16'hzzzz;

  assign OTG_INT      = r_int;
  assign mbx_in_data  = r_mbx_in_data;
  assign mbx_in_valid = r_mbx_in_valid;
  assign mbx_out_full = r_mbx_out_full;

endmodule

// File: tb/tb_hpi_target_emu.sv
// Self-checking bench for hpi_target_emu: table-driven host sequences with a
// scoreboard queue of expected read data, plus hand-written corner cases
// (interrupt latency, soft reset, hard reset mid-read, mailbox collisions).
module tb_hpi_target_emu;

  localparam logic [1:0] A_DATA = 2'b00;
  localparam logic [1:0] A_MBX  = 2'b01;
  localparam logic [1:0] A_ADDR = 2'b10;
  localparam logic [1:0] A_STAT = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] otg_data;
  logic [15:0] tb_drv;
  logic        tb_oe;
  logic [1:0]  addr;
  logic        cs_n, rd_n, wr_n, soft_rst_n;
  logic        otg_int;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;
  logic        mbx_out_full;

  assign otg_data = tb_oe ? tb_drv : 16'hzzzz;

  hpi_target_emu dut (
    .Clk          (clk),
    .Reset        (rst),
    .OTG_DATA     (otg_data),
    .OTG_ADDR     (addr),
    .OTG_CS_N     (cs_n),
    .OTG_RD_N     (rd_n),
    .OTG_WR_N     (wr_n),
    .OTG_RST_N    (soft_rst_n),
    .OTG_INT      (otg_int),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr),
    .mbx_out_full (mbx_out_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  typedef enum {OP_WR, OP_RD, OP_ACK, OP_MBXIN} op_e;
  typedef struct {
    op_e         op;
    logic [1:0]  a;
    logic [15:0] d;
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; tb_drv = d; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
  endtask

  // Expected value goes into the scoreboard when the read is launched and is
  // popped when the bus value is sampled.
  task automatic host_read(input string name, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] act;
    exp_q.push_back(exp);
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    act = otg_data;
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    check(name, act, exp_q.pop_front());
  endtask

  task automatic local_mbx_out(input logic [15:0] d);
    @(negedge clk);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge clk);
    mbx_out_wr = 1'b0;
  endtask

  task automatic local_ack();
    @(negedge clk);
    mbx_in_ack = 1'b1;
    @(negedge clk);
    mbx_in_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] act;

    rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; soft_rst_n = 1'b1;
    addr = A_DATA; tb_drv = '0; tb_oe = 1'b0;
    mbx_in_ack = 1'b0; mbx_out_data = '0; mbx_out_wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_int",       otg_int,      16'h0);
    check("rst_in_valid",  mbx_in_valid, 16'h0);
    check("rst_out_full",  mbx_out_full, 16'h0);
    check("rst_in_data",   mbx_in_data,  16'h0);
    host_read("rst_status", A_STAT, 16'h0000);
    host_read("rst_ptr",    A_ADDR, 16'h0000);

    // Table: RAM streaming through the pointer, then mailbox overrun handling
    vt.push_back('{OP_WR,    A_ADDR, 16'h0101, "wr"});
    vt.push_back('{OP_RD,    A_ADDR, 16'h0100, "addr_bit0_ignored"});
    vt.push_back('{OP_WR,    A_ADDR, 16'h0100, "wr"});
    vt.push_back('{OP_WR,    A_DATA, 16'h1111, "wr"});
    vt.push_back('{OP_WR,    A_DATA, 16'h2222, "wr"});
    vt.push_back('{OP_WR,    A_DATA, 16'h3333, "wr"});
    vt.push_back('{OP_RD,    A_ADDR, 16'h0106, "ptr_after_writes"});
    vt.push_back('{OP_WR,    A_ADDR, 16'h0100, "wr"});
    vt.push_back('{OP_RD,    A_DATA, 16'h1111, "ram_rd0"});
    vt.push_back('{OP_RD,    A_DATA, 16'h2222, "ram_rd1"});
    vt.push_back('{OP_RD,    A_DATA, 16'h3333, "ram_rd2"});
    vt.push_back('{OP_RD,    A_ADDR, 16'h0106, "ptr_after_reads"});
    vt.push_back('{OP_WR,    A_MBX,  16'h00AA, "wr"});
    vt.push_back('{OP_WR,    A_MBX,  16'h00BB, "wr"});
    vt.push_back('{OP_MBXIN, A_MBX,  16'h00BB, "mbx_in_overwrite"});
    vt.push_back('{OP_WR,    A_STAT, 16'hFFFF, "wr"});
    vt.push_back('{OP_RD,    A_STAT, 16'h0006, "status_ovr_valid"});
    vt.push_back('{OP_RD,    A_STAT, 16'h0002, "status_ovr_cleared"});
    vt.push_back('{OP_ACK,   A_MBX,  16'h0000, "ack"});
    vt.push_back('{OP_RD,    A_STAT, 16'h0000, "status_after_ack"});

    for (int i = 0; i < vt.size(); i++) begin
      case (vt[i].op)
        OP_WR:    host_write(vt[i].a, vt[i].d);
        OP_RD:    host_read(vt[i].name, vt[i].a, vt[i].d);
        OP_ACK:   local_ack();
        OP_MBXIN: check(vt[i].name, mbx_in_data, vt[i].d);
        default:  ;
      endcase
    end

    // Local->host mailbox and interrupt latency
    local_mbx_out(16'hBEEF);
    check("out_full_set",   mbx_out_full, 16'h1);
    check("int_latency_lo", otg_int,      16'h0);
    @(negedge clk);
    check("int_set",        otg_int,      16'h1);
    host_read("status_full", A_STAT, 16'h0001);
    host_read("mbx_out_rd",  A_MBX,  16'hBEEF);
    check("out_full_clr",   mbx_out_full, 16'h0);
    @(negedge clk);
    check("int_clr",        otg_int,      16'h0);
    host_read("status_empty", A_STAT, 16'h0000);

    // Pointer wrap at 0xFFFE
    host_write(A_ADDR, 16'hFFFE);
    host_write(A_DATA, 16'h5A5A);
    host_read("ptr_wrap", A_ADDR, 16'h0000);
`ifdef HPI_RANGE_ERR_EN
    host_read("status_rng",     A_STAT, 16'h8000);
    host_read("status_rng_clr", A_STAT, 16'h0000);
    host_write(A_ADDR, 16'h1000);
    host_read("rng_read_dead",  A_DATA, 16'hDEAD);
    host_read("rng_ptr_inc",    A_ADDR, 16'h1002);
    host_read("status_rng_rd",  A_STAT, 16'h8000);
`else
    host_write(A_ADDR, 16'h07FE);
    host_read("ram_alias_last", A_DATA, 16'h5A5A);
    host_read("status_no_rng",  A_STAT, 16'h0000);
`endif

    // Host soft reset held low 3 cycles; a write during it is ignored
    host_write(A_ADDR, 16'h0040);
    host_write(A_DATA, 16'hC0DE);
    host_write(A_ADDR, 16'h0040);
    local_mbx_out(16'h1234);
    @(negedge clk);
    check("pre_soft_int", otg_int, 16'h1);
    soft_rst_n = 1'b0;
    host_write(A_ADDR, 16'h0200);
    soft_rst_n = 1'b1;
    check("soft_int",      otg_int,      16'h0);
    check("soft_out_full", mbx_out_full, 16'h0);
    host_read("soft_ptr",  A_ADDR, 16'h0000);
    host_write(A_ADDR, 16'h0040);
    host_read("soft_ram_kept", A_DATA, 16'hC0DE);

    // Hard reset during a host read releases the bus immediately
    host_write(A_ADDR, 16'h0000);
    host_write(A_DATA, 16'h0F0F);
    host_write(A_ADDR, 16'h0000);
    local_mbx_out(16'h7777);
    host_write(A_MBX, 16'h0055);
    @(negedge clk);
    addr = A_DATA; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("rd_drive", otg_data, 16'h0F0F);
    check("pre_rst_int", otg_int, 16'h1);
    #2 rst = 1'b1;
    #1 tb_drv = 16'h0000; tb_oe = 1'b1;
    #1 check("rst_bus_release", otg_data, 16'h0000);
    check("rst_mid_int",      otg_int,      16'h0);
    check("rst_mid_out_full", mbx_out_full, 16'h0);
    check("rst_mid_in_valid", mbx_in_valid, 16'h0);
    check("rst_mid_in_data",  mbx_in_data,  16'h0);
    cs_n = 1'b1; rd_n = 1'b1; tb_oe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    host_read("rst_mid_ptr", A_ADDR, 16'h0000);

    // Local mailbox write coinciding with the host MAILBOX read-end
    local_mbx_out(16'h1111);
    exp_q.push_back(16'h1111);
    @(negedge clk);
    addr = A_MBX; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    act = otg_data;
    cs_n = 1'b1; rd_n = 1'b1;
    mbx_out_data = 16'h2222; mbx_out_wr = 1'b1;
    check("collide_rd", act, exp_q.pop_front());
    @(negedge clk);
    mbx_out_wr = 1'b0;
    check("collide_full", mbx_out_full, 16'h1);
    @(negedge clk);
    check("collide_int", otg_int, 16'h1);
    host_read("collide_new_data", A_MBX, 16'h2222);
    @(negedge clk);
    check("collide_int_clr", otg_int, 16'h0);

    // Host MAILBOX write coinciding with the local ack: valid stays, no overrun
    host_write(A_MBX, 16'h0011);
    @(negedge clk);
    addr = A_MBX; tb_drv = 16'h0022; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    mbx_in_ack = 1'b1;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; tb_oe = 1'b0; mbx_in_ack = 1'b0;
    check("ack_wr_data", mbx_in_data, 16'h0022);
    host_read("ack_wr_status", A_STAT, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
